// File: rtl/addr_dec_pkg.sv
// addr_dec_pkg: state encoding and widths
// shared by the region decoder files.
package addr_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  localparam int WS_W     = 4;
  localparam int NREG_MAX = 8;
  localparam int SEL_W    = $clog2(NREG_MAX);

endpackage

// File: rtl/addr_region_decoder_if.sv
// addr_region_decoder_if: CPU data-bus request side
// and decoded chip-select side of the decoder.
interface addr_region_decoder_if #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 4
);

  logic [ADDR_W-1:0] Address;
  logic              req;
  logic [NREG-1:0]   cs_n;
  logic              ready;
  logic              bus_err;
  logic              busy;

`ifdef ADDRDEC_ERR_CAPTURE_EN
  logic              err_clr;
  logic [ADDR_W-1:0] err_addr;
  logic              err_valid;

  modport master (
    output Address, req, err_clr,
    input  cs_n, ready, bus_err, busy,
    input  err_addr, err_valid
  );

  modport slave (
    input  Address, req, err_clr,
    output cs_n, ready, bus_err, busy,
    output err_addr, err_valid
  );
`else
  modport master (
    output Address, req,
    input  cs_n, ready, bus_err, busy
  );

  modport slave (
    input  Address, req,
    output cs_n, ready, bus_err, busy
  );
`endif

endinterface

// File: rtl/addr_region_match.sv
// addr_region_match: inclusive unsigned window test;
// an inverted window (base > limit) never hits.
module addr_region_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] Address,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  output logic              hit
);

  assign hit = (Address >= base) &&
               (Address <= limit);

endmodule

// File: rtl/addr_region_decoder.sv
// addr_region_decoder: multi-region decode with wait states.
// Optional fault capture: ADDRDEC_ERR_CAPTURE_EN.
module addr_region_decoder
  import addr_dec_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREG   = 4,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE =
    (NREG*ADDR_W)'(16'h0500),
  parameter logic [NREG*ADDR_W-1:0] REG_LIMIT =
    (NREG*ADDR_W)'(16'h08FF),
  parameter logic [NREG*WS_W-1:0] REG_WS = '0
) (
  input  logic clk,
  input  logic rst,
  addr_region_decoder_if.slave bus
);

  state_t            state;
  state_t            nxt;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sel_nxt;
  logic [SEL_W-1:0]  hit_idx;
  logic [WS_W-1:0]   cnt;
  logic [WS_W-1:0]   cnt_nxt;
  logic [WS_W-1:0]   ws_hit;
  logic [NREG-1:0]   hit;
  logic              hit_any;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    addr_region_match #(
      .ADDR_W(ADDR_W)
    ) u_match (
      .Address(bus.Address),
      .base   (REG_BASE[i*ADDR_W +: ADDR_W]),
      .limit  (REG_LIMIT[i*ADDR_W +: ADDR_W]),
      .hit    (hit[i])
    );
  end

  // Walk downwards so the lowest hitting index wins.
  always_comb begin
    hit_idx = '0;
    ws_hit  = '0;
    hit_any = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = SEL_W'(i);
        ws_hit  = REG_WS[i*WS_W +: WS_W];
        hit_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    sel_nxt = sel;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (hit_any) begin
            nxt     = ACCESS;
            sel_nxt = hit_idx;
            cnt_nxt = ws_hit;
          end else begin
            nxt = ERR;
          end
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs depend on registers only.
  assign bus.cs_n    = (state == ACCESS) ?
                       ~(NREG'(1) << sel) : '1;
  assign bus.ready   = (state == ACCESS) &&
                       (cnt == '0);
  assign bus.bus_err = (state == ERR);
  assign bus.busy    = (state != IDLE);

`ifdef ADDRDEC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] err_addr;
  logic              err_valid;
  logic              fault;

  assign fault = (state == IDLE) && bus.req &&
                 !hit_any;

  // A clear beats a coincident fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else if (bus.err_clr) begin
      err_valid <= 1'b0;
    end else if (fault && !err_valid) begin
      err_addr  <= bus.Address;
      err_valid <= 1'b1;
    end
  end

  assign bus.err_addr  = err_addr;
  assign bus.err_valid = err_valid;
`endif

endmodule

// File: tb/tb_addr_region_decoder.sv
// tb_addr_region_decoder: random + directed requests,
// scoreboard queue popped by a negedge monitor.
module tb_addr_region_decoder;
  import addr_dec_pkg::*;

  localparam int AW = 16;
  localparam int NR = 4;

  localparam logic [NR*AW-1:0] BASE =
    {16'h4000, 16'h0600, 16'h1000, 16'h0500};
  localparam logic [NR*AW-1:0] LIMIT =
    {16'h3000, 16'h0AFF, 16'h1FFF, 16'h08FF};
  localparam logic [NR*WS_W-1:0] WS =
    {4'd1, 4'd2, 4'd3, 4'd0};

  typedef struct {
    bit          err;
    int          region;
    int          ws;
    logic [15:0] addr;
  } exp_t;

  int base_m[NR] = '{32'h0500, 32'h1000, 32'h0600, 32'h4000};
  int lim_m[NR]  = '{32'h08FF, 32'h1FFF, 32'h0AFF, 32'h3000};
  int ws_m[NR]   = '{0, 3, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   busy_run = 0;
  int   low_reg = -1;

  addr_region_decoder_if #(.ADDR_W(AW), .NREG(NR)) bus();

  addr_region_decoder #(
    .ADDR_W   (AW),
    .NREG     (NR),
    .REG_BASE (BASE),
    .REG_LIMIT(LIMIT),
    .REG_WS   (WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a);
    exp_t e;
    e.err = 1'b1;
    e.region = -1;
    e.ws = 0;
    e.addr = a;
    for (int i = 0; i < NR; i++) begin
      if (e.err && int'(a) >= base_m[i] &&
          int'(a) <= lim_m[i]) begin
        e.err = 1'b0;
        e.region = i;
        e.ws = ws_m[i];
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", bus.busy, 0);
  endtask

  task automatic issue(input logic [15:0] a);
    wait_idle();
    bus.Address = a;
    bus.req = 1'b1;
    q.push_back(model(a));
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      chk("no_both", bus.ready & bus.bus_err, 0);
      if (bus.cs_n != '1) begin
        chk("cs_onehot", $countones(~bus.cs_n), 1);
        for (int i = 0; i < NR; i++)
          if (!bus.cs_n[i]) low_reg = i;
        run++;
      end
      if (bus.ready || bus.bus_err) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          me = q.pop_front();
          chk("kind", bus.bus_err, me.err);
          if (bus.ready) begin
            chk("region", low_reg, me.region);
            chk("cs_cycles", run, me.ws + 1);
            chk("busy_cycles", busy_run, me.ws + 1);
          end else begin
            chk("err_cs", bus.cs_n, 4'hF);
            chk("err_busy", busy_run, 1);
            chk("err_run", run, 0);
          end
        end
        run = 0;
        busy_run = 0;
      end
    end
  end

  initial begin
    logic [15:0] a;
    int n;
    bus.Address = '0;
    bus.req = 1'b0;
`ifdef ADDRDEC_ERR_CAPTURE_EN
    bus.err_clr = 1'b0;
`endif
    #1;
    chk("rst_cs", bus.cs_n, 4'hF);
    chk("rst_ready", bus.ready, 0);
    chk("rst_err", bus.bus_err, 0);
    chk("rst_busy", bus.busy, 0);
`ifdef ADDRDEC_ERR_CAPTURE_EN
    chk("rst_eaddr", bus.err_addr, 0);
    chk("rst_evalid", bus.err_valid, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(16'h0500);
    issue(16'h08FF);
    issue(16'h04FF);
    issue(16'h0900);
    issue(16'h1234);
    issue(16'h0600);
    issue(16'h0A00);
    issue(16'h3800);
    issue(16'h0000);

    // req held, address wiggled while in ACCESS
    wait_idle();
    bus.Address = 16'h0700;
    bus.req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      q.push_back(model(16'h0700));
      @(negedge clk);
      chk("held_ready", bus.ready, 1);
      bus.Address = 16'hF000;
      @(negedge clk);
      chk("held_idle", bus.busy, 0);
      bus.Address = 16'h0700;
      if (k == 5) bus.req = 1'b0;
    end

    // reset in the second cycle of a WS=3 access
    wait_idle();
    bus.Address = 16'h1234;
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_cs", bus.cs_n, 4'hF);
    chk("midrst_ready", bus.ready, 0);
    chk("midrst_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h1234);

    for (int k = 0; k < 60; k++) begin
      int r;
      int m;
      r = $urandom_range(0, NR - 1);
      m = $urandom_range(0, 3);
      case (m)
        0: a = 16'($urandom);
        1: a = 16'(base_m[r] + $urandom_range(0, 2) - 1);
        2: a = 16'(lim_m[r] + $urandom_range(0, 2) - 1);
        default: a = 16'(base_m[r] + $urandom_range(0, 255));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a);
    end

`ifdef ADDRDEC_ERR_CAPTURE_EN
    wait_idle();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("clr_valid", bus.err_valid, 0);
    issue(16'hF000);
    issue(16'hE000);
    chk("cap_addr", bus.err_addr, 16'hF000);
    chk("cap_valid", bus.err_valid, 1);
    wait_idle();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("clr2_valid", bus.err_valid, 0);
    issue(16'hE000);
    chk("cap2_addr", bus.err_addr, 16'hE000);
    chk("cap2_valid", bus.err_valid, 1);
    // clear coinciding with a new fault
    wait_idle();
    bus.Address = 16'hD000;
    bus.req = 1'b1;
    bus.err_clr = 1'b1;
    q.push_back(model(16'hD000));
    @(negedge clk);
    bus.req = 1'b0;
    bus.err_clr = 1'b0;
    chk("coinc_valid", bus.err_valid, 0);
    chk("coinc_addr", bus.err_addr, 16'hE000);
`endif

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_region_decoder.md
# addr_region_decoder

Parametrised multi-region address decoder with per-region wait-state generation for the MIPS CPU data bus. It compares each bus request address against NREG base/limit windows and drives one active-low chip select per region. It holds that select for a programmable number of wait states, then signals completion with ready, or signals bus_err for unmapped addresses. It sits between the CPU load/store unit and the memory/peripheral chip selects, replacing single-window fixed decoding.

## Interface

Parameters:
- ADDR_W, 16, address bus width.
- NREG, 4, number of decoded regions (1..8).
- REG_BASE, {NREG{ADDR_W'h0}} packed, region 0 = 16'h0500; inclusive lower bound per region, region i at bits [i*ADDR_W +: ADDR_W].
- REG_LIMIT, packed like REG_BASE, region 0 = 16'h08FF; inclusive upper bound per region.
- REG_WS, packed 4 bits per region, region 0 = 4'd0; wait states per region (0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- Address  in  ADDR_W  request address, sampled with req.
- req  in  1  access request, sampled only in IDLE.
- err_clr  in  1  clears captured error (only with ADDRDEC_ERR_CAPTURE_EN).
- cs_n  out  NREG  active-low chip selects, one-hot-low or all-high.
- ready  out  1  one-cycle access-complete strobe.
- bus_err  out  1  one-cycle unmapped-access strobe.
- busy  out  1  high in any state other than IDLE.
- err_addr  out  ADDR_W  captured faulting address (only with ADDRDEC_ERR_CAPTURE_EN).
- err_valid  out  1  sticky error-captured flag (only with ADDRDEC_ERR_CAPTURE_EN).

## Operation

- States: IDLE, ACCESS, ERR.
- Hit for region i: REG_BASE[i] <= Address <= REG_LIMIT[i], unsigned compare at full ADDR_W.
- Overlap: lowest index hit wins; exactly one cs_n bit goes low.
- IDLE, req=1, hit on region i: Address is latched, sel<=i, cnt<=REG_WS[i], next=ACCESS.
- IDLE, req=1, no hit: next=ERR.
- IDLE, req=0: stay.
- ACCESS: cs_n[sel]=0. If cnt!=0, cnt decrements and the state stays ACCESS. If cnt==0, ready=1 and next=IDLE.
- ERR: bus_err=1, cs_n all high, next=IDLE.
- req in ACCESS/ERR is ignored; requester must hold req until ready/bus_err or re-issue after.
- A region with REG_BASE > REG_LIMIT never hits; this is not an error at elaboration.
- All outputs are decoded from registered state only, so they are glitch-free.

## Timing

- Reset values: state=IDLE; cs_n all 1; ready=0; bus_err=0; busy=0; cnt=0; err_addr=0; err_valid=0.
- Reset asserted mid-ACCESS: cs_n released immediately (async), no ready issued.
- Latency: cs_n low in the cycle after the sampling edge, for REG_WS+1 cycles. ready is high in the last of those cycles.
- Throughput: one access per REG_WS+2 cycles. IDLE takes one cycle between accesses.
- Unmapped access: bus_err is high for exactly 1 cycle, 1 cycle after the sampling edge. ready stays 0.
- ready and bus_err are never high together.

## Configuration

- ADDRDEC_ERR_CAPTURE_EN defined:
  - On entry to ERR, err_addr<=latched Address and err_valid<=1, but only if err_valid was 0 (first fault wins).
  - err_clr=1 clears err_valid on the next edge.
  - If err_clr and a new fault coincide, the clear wins and the new fault is not captured.
- Not defined: the err_addr, err_valid and err_clr ports and their registers are absent. bus_err behaviour is unchanged.

## Structure

- Package addr_dec_pkg holds the state encoding constants (IDLE=2'd0, ACCESS=2'd1, ERR=2'd2), the WS_W=4 width and the NREG_MAX=8 bound.
- Sub-module addr_region_match: combinational, one per region via generate. Inputs are Address, base and limit; output is hit.
- The top module contains the priority encoder, the FSM, the wait counter and the optional error capture.

## Test plan

- Default params, req with Address=16'h0500 -> cs_n[0]=0 for 1 cycle with ready=1 that cycle; 16'h08FF same; 16'h04FF and 16'h0900 -> bus_err pulse, cs_n all high.
- Region 1 = 16'h1000..16'h1FFF, WS=3, req at 16'h1234 -> cs_n[1]=0 for 4 cycles, ready only in the 4th, busy for 4 cycles.
- Regions 0 and 2 overlapping at 16'h0600, req 16'h0600 -> only cs_n[0]=0.
- req held continuously at 16'h0700 with WS=0 -> cs_n/ready pulses every 2 cycles; a mid-ACCESS Address change is ignored.
- rst pulsed during the 2nd cycle of a WS=3 access -> cs_n all 1 immediately, no ready, next req is served normally.
- With ADDRDEC_ERR_CAPTURE_EN, faults at 16'hF000 then 16'hE000 -> err_addr=16'hF000, err_valid=1; after err_clr, a fault at 16'hE000 -> err_addr=16'hE000.
